// File: rtl/xor_quad_arbiter_if.sv
// rtl/xor_quad_arbiter_if.sv - requester/gate bundle for the shared quad XOR arbiter
// Optional par signal present when XOR_ARB_PARITY_EN is defined.
interface xor_quad_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a;
    logic [NREQ*W-1:0] b;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      y;
    logic              busy;
    logic [W-1:0]      xa;
    logic [W-1:0]      xb;
    logic [W-1:0]      xy;
`ifdef XOR_ARB_PARITY_EN
    logic              par;

    modport slave (
        input  req, a, b, xy,
        output gnt, done, y, busy, xa, xb, par
    );
    modport master (
        output req, a, b, xy,
        input  gnt, done, y, busy, xa, xb, par
    );
`else
    modport slave (
        input  req, a, b, xy,
        output gnt, done, y, busy, xa, xb
    );
    modport master (
        output req, a, b, xy,
        input  gnt, done, y, busy, xa, xb
    );
`endif
endinterface

// File: rtl/xor_quad_arbiter.sv
// rtl/xor_quad_arbiter.sv - round-robin time-sharing of one quad XOR gate among NREQ requesters
// XOR_ARB_PARITY_EN adds a registered parity output captured alongside y.
module xor_quad_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    xor_quad_arbiter_if.slave    bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n;
    logic [IW-1:0]   gidx, gidx_n;
    logic [IW-1:0]   pick;
    logic            found;
    logic [NREQ-1:0] gnt_q, gnt_n;
    logic [NREQ-1:0] done_q, done_n;
    logic [W-1:0]    y_q, y_n;
    logic [W-1:0]    xa_q, xa_n;
    logic [W-1:0]    xb_q, xb_n;
`ifdef XOR_ARB_PARITY_EN
    logic            par_q, par_n;
`endif

    // First pending requester at or after ptr, wrapping past NREQ-1.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req[j]) begin
                found = 1'b1;
                pick  = IW'(j);
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gidx_n  = gidx;
        gnt_n   = gnt_q;
        done_n  = done_q;
        y_n     = y_q;
        xa_n    = xa_q;
        xb_n    = xb_q;
`ifdef XOR_ARB_PARITY_EN
        par_n   = par_q;
`endif
        case (state)
            IDLE: begin
                done_n = '0;
                gnt_n  = '0;
                xa_n   = '0;
                xb_n   = '0;
                if (found) begin
                    gnt_n[pick] = 1'b1;
                    gidx_n      = pick;
                    xa_n        = bus.a[int'(pick)*W +: W];
                    xb_n        = bus.b[int'(pick)*W +: W];
                    state_n     = DRIVE;
                end
            end
            DRIVE: begin
                // Gate output has settled for a full cycle; grant drops so gnt and done never overlap.
                y_n     = bus.xy;
                done_n  = gnt_q;
                gnt_n   = '0;
                xa_n    = '0;
                xb_n    = '0;
`ifdef XOR_ARB_PARITY_EN
                par_n   = ^bus.xy;
`endif
                state_n = CAPTURE;
            end
            CAPTURE: begin
                done_n  = '0;
                ptr_n   = (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            gidx   <= '0;
            gnt_q  <= '0;
            done_q <= '0;
            y_q    <= '0;
            xa_q   <= '0;
            xb_q   <= '0;
`ifdef XOR_ARB_PARITY_EN
            par_q  <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            gidx   <= gidx_n;
            gnt_q  <= gnt_n;
            done_q <= done_n;
            y_q    <= y_n;
            xa_q   <= xa_n;
            xb_q   <= xb_n;
`ifdef XOR_ARB_PARITY_EN
            par_q  <= par_n;
`endif
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.y    = y_q;
    assign bus.xa   = xa_q;
    assign bus.xb   = xb_q;
    assign bus.busy = (state != IDLE);
`ifdef XOR_ARB_PARITY_EN
    assign bus.par  = par_q;
`endif

endmodule

// File: tb/tb_xor_quad_arbiter.sv
// tb/tb_xor_quad_arbiter.sv - directed and randomized checks of xor_quad_arbiter against a round-robin model
// Parity checks compiled in when XOR_ARB_PARITY_EN is defined.
module tb_xor_quad_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cyc = -1;
    int   mptr = 0;

    xor_quad_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    xor_quad_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational quad XOR package on the board.
    assign bus.xy = bus.xa ^ bus.xb;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: lowest index at or after p, counting modulo NREQ.
    function automatic int pick_model(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    // One full grant/drive/capture sequence starting from an IDLE cycle.
    task automatic do_op(input int idx, input logic [W-1:0] ea, input logic [W-1:0] eb,
                         input logic [W-1:0] late, input bit drop, input logic [NREQ-1:0] add);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        step();
        chk("gnt", 32'(bus.gnt), 32'(oh));
        chk("xa", 32'(bus.xa), 32'(ea));
        chk("xb", 32'(bus.xb), 32'(eb));
        chk("busy_drive", 32'(bus.busy), 32'd1);
        chk("done_drive", 32'(bus.done), 32'd0);
        bus.a[idx*W +: W] = late;
        bus.req = bus.req | add;
        step();
        done_cyc = cyc;
        chk("done", 32'(bus.done), 32'(oh));
        chk("gnt_capture", 32'(bus.gnt), 32'd0);
        chk("y", 32'(bus.y), 32'(ea ^ eb));
        chk("busy_capture", 32'(bus.busy), 32'd1);
`ifdef XOR_ARB_PARITY_EN
        chk("par", 32'(bus.par), 32'(^(ea ^ eb)));
`endif
        if (drop) bus.req[idx] = 1'b0;
        step();
        chk("done_idle", 32'(bus.done), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("y_hold", 32'(bus.y), 32'(ea ^ eb));
    endtask

    initial begin
        int last;
        int e;
        logic [NREQ-1:0] r;

        rst = 1'b1;
        bus.req = 4'b1111;
        bus.a = '0;
        bus.b = '0;
        step();
        step();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_xa", 32'(bus.xa), 32'd0);
        chk("rst_xb", 32'(bus.xb), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef XOR_ARB_PARITY_EN
        chk("rst_par", 32'(bus.par), 32'd0);
`endif

        // Fairness: all four request, each drops on its done.
        bus.a = 16'h9C5A;
        bus.b = 16'h3E71;
        rst = 1'b0;
        last = -1;
        for (int i = 0; i < NREQ; i++) begin
            logic [15:0] av, bv;
            av = 16'h9C5A;
            bv = 16'h3E71;
            do_op(i, av[i*W +: W], bv[i*W +: W], 4'h0, 1'b1, '0);
            if (last >= 0) chk("done_spacing", 32'(done_cyc - last), 32'd3);
            last = done_cyc;
        end
        mptr = 0;

        // Single op on requester 2.
        bus.req = 4'b0100;
        bus.a[8 +: 4] = 4'hA;
        bus.b[8 +: 4] = 4'h6;
        do_op(2, 4'hA, 4'h6, 4'h1, 1'b1, '0);
        chk("single_y", 32'(bus.y), 32'hC);
        mptr = 3;

        // Stuck requester 1 with requester 3 arriving during its operation.
        bus.req = 4'b0010;
        bus.a[4 +: 4] = 4'h3;
        bus.b[4 +: 4] = 4'h9;
        do_op(1, 4'h3, 4'h9, 4'h3, 1'b0, 4'b1000);
        bus.a[12 +: 4] = 4'hE;
        bus.b[12 +: 4] = 4'h4;
        do_op(3, 4'hE, 4'h4, 4'hE, 1'b1, '0);
        do_op(1, 4'h3, 4'h9, 4'h3, 1'b1, '0);
        mptr = 2;

        // Operand change during DRIVE is ignored.
        bus.req = 4'b0001;
        bus.a[0 +: 4] = 4'h5;
        bus.b[0 +: 4] = 4'h3;
        do_op(0, 4'h5, 4'h3, 4'hF, 1'b1, '0);
        chk("latched_y", 32'(bus.y), 32'h6);
        mptr = 1;

        // Reset during DRIVE aborts and rewinds the pointer.
        bus.req = 4'b1000;
        step();
        chk("pre_abort_gnt", 32'(bus.gnt), 32'b1000);
        rst = 1'b1;
        step();
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_gnt", 32'(bus.gnt), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_y", 32'(bus.y), 32'd0);
        rst = 1'b0;
        bus.req = 4'b1001;
        bus.a[0 +: 4] = 4'h5;
        bus.b[0 +: 4] = 4'h2;
        do_op(0, 4'h5, 4'h2, 4'h0, 1'b1, '0);
        chk("after_abort_y", 32'(bus.y), 32'h7);
        mptr = 1;

        // Randomized traffic against the round-robin model.
        for (int it = 0; it < 60; it++) begin
            r = 4'($urandom_range(0, 15));
            bus.req = r;
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            e = pick_model(r, mptr);
            if (e < 0) begin
                step();
                chk("rand_nogrant", 32'(bus.gnt), 32'd0);
                chk("rand_idle_busy", 32'(bus.busy), 32'd0);
            end else begin
                do_op(e, bus.a[e*W +: W], bus.b[e*W +: W], 4'($urandom),
                      1'($urandom_range(0, 1)), 4'($urandom));
                mptr = (e + 1) % NREQ;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
